// File: rtl/cim_router_pkg.sv
// Address map, CSR offsets, error patterns and state types shared by the CIM router
// and its register block.
package cim_router_pkg;

   localparam logic [31:0] WinMask = 32'hFFFF_F000;
   localparam logic [31:0] S0Base  = 32'h0000_0000;
   localparam logic [31:0] S1Base  = 32'h0000_1000;
   localparam logic [31:0] CsrBase = 32'h0000_2000;

   localparam logic [11:0] OffCtrl    = 12'h000;
   localparam logic [11:0] OffTimeout = 12'h004;
   localparam logic [11:0] OffStatus  = 12'h008;
   localparam logic [11:0] OffCnt0    = 12'h00C;
   localparam logic [11:0] OffCnt1    = 12'h010;

   localparam logic [31:0] DeadUnmapped = 32'hDEAD_0000;
   localparam logic [31:0] DeadTimeout  = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      StIdle,
      StFwd0,
      StFwd1,
      StResp
   } state_e;

   typedef enum logic [1:0] {
      TgtS0,
      TgtS1,
      TgtCsr,
      TgtNone
   } target_e;

   function automatic target_e decode_target(input logic [31:0] adr);
      logic [31:0] win;
      win = adr & WinMask;
      if (win == S0Base) return TgtS0;
      if (win == S1Base) return TgtS1;
      if (win == CsrBase) return TgtCsr;
      return TgtNone;
   endfunction

endpackage

// File: rtl/wb_cim_router_if.sv
// Host-side Wishbone bus of the CIM router; slave modport is the router's view,
// master modport is the host's view.
interface wb_cim_router_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i,
      input  wbs_stb_i,
      input  wbs_we_i,
      input  wbs_sel_i,
      input  wbs_adr_i,
      input  wbs_dat_i,
      output wbs_ack_o,
      output wbs_dat_o
   );

   modport master (
      output wbs_cyc_i,
      output wbs_stb_i,
      output wbs_we_i,
      output wbs_sel_i,
      output wbs_adr_i,
      output wbs_dat_i,
      input  wbs_ack_o,
      input  wbs_dat_o
   );

endinterface

// File: rtl/cim_router_csr.sv
// Control/status registers of the CIM router: slave enables, timeout reload value,
// sticky timeout errors and per-slave saturating transaction counters.
module cim_router_csr
   import cim_router_pkg::*;
#(
   parameter logic [15:0] TO_RST = 16'h00FF,
   parameter int unsigned CNT_W  = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_en_i,
   input  logic [11:0] offset_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] rdata_o,
   input  logic        busy_i,
   input  logic [1:0]  to_err_set_i,
   input  logic [1:0]  cnt_inc_i,
   output logic [1:0]  en_o,
   output logic [15:0] timeout_o,
   output logic        irq_o
);

   logic [1:0]       en_q, en_d;
   logic [15:0]      timeout_q, timeout_d;
   logic [1:0]       to_err_q, to_err_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   always_comb begin
      en_d      = en_q;
      timeout_d = timeout_q;
      to_err_d  = to_err_q | to_err_set_i;
      cnt0_d    = cnt0_q;
      cnt1_d    = cnt1_q;
      if (cnt_inc_i[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
      if (cnt_inc_i[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
      if (wr_en_i) begin
         case (offset_i)
            OffCtrl:    en_d      = wdata_i[1:0];
            OffTimeout: timeout_d = wdata_i;
            // A new timeout error in the same cycle outranks the clear.
            OffStatus:  to_err_d  = (to_err_q & ~wdata_i[1:0]) | to_err_set_i;
            OffCnt0:    cnt0_d    = '0;
            OffCnt1:    cnt1_d    = '0;
            default:    ;
         endcase
      end
   end

   always_comb begin
      rdata_o = '0;
      case (offset_i)
         OffCtrl:    rdata_o = {30'b0, en_q};
         OffTimeout: rdata_o = {16'b0, timeout_q};
         OffStatus:  rdata_o = {29'b0, busy_i, to_err_q};
         OffCnt0:    rdata_o = 32'(cnt0_q);
         OffCnt1:    rdata_o = 32'(cnt1_q);
         default:    rdata_o = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q      <= 2'b11;
         timeout_q <= TO_RST;
         to_err_q  <= 2'b00;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         en_q      <= en_d;
         timeout_q <= timeout_d;
         to_err_q  <= to_err_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
      end
   end

   assign en_o      = en_q;
   assign timeout_o = timeout_q;
   assign irq_o     = |to_err_q;

endmodule

// File: rtl/wb_cim_router.sv
// Wishbone router from one host to two CIM macro slaves plus a CSR window; one
// transaction in flight, per-transaction timeout, registered ack and read data.
module wb_cim_router
   import cim_router_pkg::*;
#(
   parameter logic [15:0] TO_RST = 16'h00FF,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
   wb_cim_router_if.slave        wbs,
   output logic                  s0_cyc_o,
   output logic                  s0_stb_o,
   output logic                  s1_cyc_o,
   output logic                  s1_stb_o,
   output logic                  s_we_o,
   output logic [3:0]            s_sel_o,
   output logic [31:0]           s_adr_o,
   output logic [31:0]           s_dat_o,
   input  logic                  s0_ack_i,
   input  logic                  s1_ack_i,
   input  logic [31:0]           s0_dat_i,
   input  logic [31:0]           s1_dat_i,
   output logic                  irq_o
);

   state_e      state_q, state_d;
   logic [31:0] dat_q, dat_d;
   logic        ack_q, ack_d;
   logic        s0_stb_q, s0_stb_d;
   logic        s1_stb_q, s1_stb_d;
   logic [15:0] to_cnt_q, to_cnt_d;

   logic        req;
   target_e     tgt;
   logic        fwd_idx;
   logic        fwd_ack;
   logic [31:0] fwd_dat;
   logic        busy;
   logic        csr_wr;
   logic [31:0] csr_rdata;
   logic [1:0]  en;
   logic [15:0] timeout;
   logic [1:0]  to_err_set;
   logic [1:0]  cnt_inc;

   assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
   assign tgt     = decode_target(wbs.wbs_adr_i);
   assign fwd_idx = (state_q == StFwd1);
   assign fwd_ack = fwd_idx ? s1_ack_i : s0_ack_i;
   assign fwd_dat = fwd_idx ? s1_dat_i : s0_dat_i;
   assign busy    = (state_q == StFwd0) || (state_q == StFwd1);

   always_comb begin
      state_d    = state_q;
      dat_d      = dat_q;
      ack_d      = 1'b0;
      s0_stb_d   = s0_stb_q;
      s1_stb_d   = s1_stb_q;
      to_cnt_d   = to_cnt_q;
      csr_wr     = 1'b0;
      to_err_set = 2'b00;
      cnt_inc    = 2'b00;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               unique case (tgt)
                  TgtS0: begin
                     if (en[0]) begin
                        state_d  = StFwd0;
                        s0_stb_d = 1'b1;
                        to_cnt_d = timeout;
                     end else begin
                        state_d = StResp;
                        dat_d   = DeadUnmapped;
                     end
                  end
                  TgtS1: begin
                     if (en[1]) begin
                        state_d  = StFwd1;
                        s1_stb_d = 1'b1;
                        to_cnt_d = timeout;
                     end else begin
                        state_d = StResp;
                        dat_d   = DeadUnmapped;
                     end
                  end
                  TgtCsr: begin
                     state_d = StResp;
                     dat_d   = csr_rdata;
                     csr_wr  = wbs.wbs_we_i;
                  end
                  TgtNone: begin
                     state_d = StResp;
                     dat_d   = DeadUnmapped;
                  end
               endcase
            end
         end
         StFwd0, StFwd1: begin
            // Abandoned by the host: no ack, no counter update.
            if (!wbs.wbs_cyc_i) begin
               state_d  = StIdle;
               s0_stb_d = 1'b0;
               s1_stb_d = 1'b0;
            end else if (fwd_ack) begin
               state_d          = StResp;
               dat_d            = fwd_dat;
               s0_stb_d         = 1'b0;
               s1_stb_d         = 1'b0;
               cnt_inc[fwd_idx] = 1'b1;
            end else if (to_cnt_q == 16'd1) begin
               state_d             = StResp;
               dat_d               = DeadTimeout;
               s0_stb_d            = 1'b0;
               s1_stb_d            = 1'b0;
               to_err_set[fwd_idx] = 1'b1;
            end else if (to_cnt_q != 16'd0) begin
               // A zero load never counts down, which disables the timeout.
               to_cnt_d = to_cnt_q - 16'd1;
            end
         end
         StResp: begin
            ack_d   = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= StIdle;
         dat_q    <= 32'h0;
         ack_q    <= 1'b0;
         s0_stb_q <= 1'b0;
         s1_stb_q <= 1'b0;
         to_cnt_q <= 16'h0;
      end else begin
         state_q  <= state_d;
         dat_q    <= dat_d;
         ack_q    <= ack_d;
         s0_stb_q <= s0_stb_d;
         s1_stb_q <= s1_stb_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   cim_router_csr #(
      .TO_RST (TO_RST),
      .CNT_W  (CNT_W)
   ) u_csr (
      .clk_i        (wb_clk_i),
      .rst_ni       (wb_rst_ni),
      .wr_en_i      (csr_wr),
      .offset_i     (wbs.wbs_adr_i[11:0]),
      .wdata_i      (wbs.wbs_dat_i[15:0]),
      .rdata_o      (csr_rdata),
      .busy_i       (busy),
      .to_err_set_i (to_err_set),
      .cnt_inc_i    (cnt_inc),
      .en_o         (en),
      .timeout_o    (timeout),
      .irq_o        (irq_o)
   );

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign s0_cyc_o      = s0_stb_q;
   assign s0_stb_o      = s0_stb_q;
   assign s1_cyc_o      = s1_stb_q;
   assign s1_stb_o      = s1_stb_q;
   assign s_we_o        = wbs.wbs_we_i;
   assign s_sel_o       = wbs.wbs_sel_i;
   assign s_adr_o       = wbs.wbs_adr_i;
   assign s_dat_o       = wbs.wbs_dat_i;

endmodule

// File: tb/tb_wb_cim_router.sv
// Directed bench for wb_cim_router: host transactions driven on the falling edge,
// scripted slave responders, inline checks against hand-computed values.
module tb_wb_cim_router;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o;
   logic        s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s0_ack_i = 1'b0;
   logic        s1_ack_i = 1'b0;
   logic [31:0] s0_dat_i = 32'h0;
   logic [31:0] s1_dat_i = 32'h0;
   logic        irq_o;

   int n_chk = 0;
   int n_pass = 0;
   logic seen_s0, seen_s1;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_cim_router_if bus ();

   wb_cim_router #(
      .TO_RST (16'h00FF),
      .CNT_W  (16)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .wbs       (bus),
      .s0_cyc_o  (s0_cyc_o),
      .s0_stb_o  (s0_stb_o),
      .s1_cyc_o  (s1_cyc_o),
      .s1_stb_o  (s1_stb_o),
      .s_we_o    (s_we_o),
      .s_sel_o   (s_sel_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s0_ack_i  (s0_ack_i),
      .s1_ack_i  (s1_ack_i),
      .s0_dat_i  (s0_dat_i),
      .s1_dat_i  (s1_dat_i),
      .irq_o     (irq_o)
   );

   task automatic drive_idle();
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
   endtask

   // Single host transaction; lat counts falling edges from request to ack.
   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                          input int max_cyc, output logic got_ack, output logic [31:0] rdat,
                          output int lat);
      got_ack = 1'b0;
      rdat    = 32'h0;
      lat     = 0;
      seen_s0 = 1'b0;
      seen_s1 = 1'b0;
      @(negedge wb_clk_i);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = 4'hF;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      while (lat < max_cyc && !got_ack) begin
         @(negedge wb_clk_i);
         lat++;
         if (s0_cyc_o || s0_stb_o) seen_s0 = 1'b1;
         if (s1_cyc_o || s1_stb_o) seen_s1 = 1'b1;
         if (bus.wbs_ack_o) begin
            got_ack = 1'b1;
            rdat    = bus.wbs_dat_o;
         end
      end
      drive_idle();
   endtask

   // Acks once, `delay` falling edges after the slave's strobe is first seen.
   task automatic slave_respond(input int idx, input int delay, input logic [31:0] data);
      int n = 0;
      while (n < 50 && !(idx == 1 ? s1_stb_o : s0_stb_o)) begin
         @(negedge wb_clk_i);
         n++;
      end
      if (n < 50) begin
         repeat (delay) @(negedge wb_clk_i);
         if (idx == 1) begin
            s1_ack_i = 1'b1;
            s1_dat_i = data;
         end else begin
            s0_ack_i = 1'b1;
            s0_dat_i = data;
         end
         @(negedge wb_clk_i);
         s0_ack_i = 1'b0;
         s1_ack_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic ok;
      logic [31:0] rd;
      int lat;
      drive_idle();
      wb_rst_ni = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      n_chk++;
      if ({bus.wbs_ack_o, irq_o} !== 2'b00)
         $display("FAIL rst_ack_irq: got %b, expected 00", {bus.wbs_ack_o, irq_o});
      else n_pass++;
      n_chk++;
      if (bus.wbs_dat_o !== 32'h0) $display("FAIL rst_dat: got %h, expected 0", bus.wbs_dat_o);
      else n_pass++;
      n_chk++;
      if ({s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o} !== 4'b0000)
         $display("FAIL rst_strobes: got %b, expected 0000",
                  {s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o});
      else n_pass++;
      wb_rst_ni = 1'b1;
      wb_xfer(32'h0000_2000, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'h0000_0003})
         $display("FAIL rst_ctrl: got ack=%b %h, expected ack=1 00000003", ok, rd);
      else n_pass++;
      n_chk++;
      if (lat !== 2) $display("FAIL csr_latency: got %0d, expected 2", lat);
      else n_pass++;
      wb_xfer(32'h0000_2004, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h0000_00FF) $display("FAIL rst_timeout: got %h, expected 000000ff", rd);
      else n_pass++;
      wb_xfer(32'h0000_2008, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h0) $display("FAIL rst_status: got %h, expected 0", rd);
      else n_pass++;
      wb_xfer(32'h0000_200C, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h0) $display("FAIL rst_cnt0: got %h, expected 0", rd);
      else n_pass++;
   endtask

   task automatic test_slave_read();
      logic ok;
      logic [31:0] rd;
      int lat;
      fork
         slave_respond(1, 3, 32'h1234_5678);
         wb_xfer(32'h0000_1004, 1'b0, 32'h0, 20, ok, rd, lat);
      join
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'h1234_5678})
         $display("FAIL s1_read: got ack=%b %h, expected ack=1 12345678", ok, rd);
      else n_pass++;
      n_chk++;
      if ({seen_s0, seen_s1} !== 2'b01)
         $display("FAIL s1_strobes: got s0/s1 seen=%b, expected 01", {seen_s0, seen_s1});
      else n_pass++;
      wb_xfer(32'h0000_2010, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h1) $display("FAIL s1_cnt: got %h, expected 1", rd);
      else n_pass++;
   endtask

   task automatic test_unmapped();
      logic ok;
      logic [31:0] rd;
      int lat;
      wb_xfer(32'h0000_5000, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'hDEAD_0000})
         $display("FAIL unmapped_dat: got ack=%b %h, expected ack=1 dead0000", ok, rd);
      else n_pass++;
      n_chk++;
      if (lat !== 2) $display("FAIL unmapped_latency: got %0d, expected 2", lat);
      else n_pass++;
      n_chk++;
      if ({seen_s0, seen_s1} !== 2'b00)
         $display("FAIL unmapped_strobes: got %b, expected 00", {seen_s0, seen_s1});
      else n_pass++;
      @(negedge wb_clk_i);
      n_chk++;
      if (bus.wbs_ack_o !== 1'b0) $display("FAIL ack_one_cycle: got %b, expected 0", bus.wbs_ack_o);
      else n_pass++;
   endtask

   task automatic test_disabled_slave();
      logic ok;
      logic [31:0] rd;
      int lat;
      wb_xfer(32'h0000_2000, 1'b1, 32'h0000_0001, 10, ok, rd, lat);
      wb_xfer(32'h0000_1000, 1'b1, 32'hAAAA_5555, 10, ok, rd, lat);
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'hDEAD_0000})
         $display("FAIL disabled_dat: got ack=%b %h, expected ack=1 dead0000", ok, rd);
      else n_pass++;
      n_chk++;
      if ({seen_s1, lat} !== {1'b0, 32'd2})
         $display("FAIL disabled_s1: got seen=%b lat=%0d, expected seen=0 lat=2", seen_s1, lat);
      else n_pass++;
      wb_xfer(32'h0000_2010, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h1) $display("FAIL disabled_cnt1: got %h, expected 1", rd);
      else n_pass++;
      wb_xfer(32'h0000_2000, 1'b1, 32'h0000_0003, 10, ok, rd, lat);
   endtask

   task automatic test_timeout();
      logic ok;
      logic [31:0] rd;
      int lat;
      wb_xfer(32'h0000_2004, 1'b1, 32'h0000_0004, 10, ok, rd, lat);
      wb_xfer(32'h0000_0000, 1'b0, 32'h0, 20, ok, rd, lat);
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'hDEAD_BEEF})
         $display("FAIL timeout_dat: got ack=%b %h, expected ack=1 deadbeef", ok, rd);
      else n_pass++;
      n_chk++;
      if (lat !== 6) $display("FAIL timeout_latency: got %0d, expected 6", lat);
      else n_pass++;
      wb_xfer(32'h0000_2008, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if ({irq_o, rd} !== {1'b1, 32'h1})
         $display("FAIL timeout_status: got irq=%b %h, expected irq=1 00000001", irq_o, rd);
      else n_pass++;
      wb_xfer(32'h0000_2008, 1'b1, 32'h0000_0001, 10, ok, rd, lat);
      n_chk++;
      if (irq_o !== 1'b0) $display("FAIL irq_clear: got %b, expected 0", irq_o);
      else n_pass++;
   endtask

   task automatic test_ack_vs_timeout();
      logic ok;
      logic [31:0] rd;
      int lat;
      // TIMEOUT is still 4: the ack lands on the expiry cycle.
      fork
         slave_respond(0, 3, 32'hCAFE_F00D);
         wb_xfer(32'h0000_0010, 1'b0, 32'h0, 20, ok, rd, lat);
      join
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'hCAFE_F00D})
         $display("FAIL ack_wins_dat: got ack=%b %h, expected ack=1 cafef00d", ok, rd);
      else n_pass++;
      wb_xfer(32'h0000_2008, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if ({irq_o, rd} !== {1'b0, 32'h0})
         $display("FAIL ack_wins_status: got irq=%b %h, expected irq=0 0", irq_o, rd);
      else n_pass++;
      wb_xfer(32'h0000_200C, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h1) $display("FAIL ack_wins_cnt0: got %h, expected 1", rd);
      else n_pass++;
   endtask

   task automatic test_timeout_disabled();
      logic ok;
      logic [31:0] rd;
      int lat;
      wb_xfer(32'h0000_2004, 1'b1, 32'h0, 10, ok, rd, lat);
      fork
         slave_respond(0, 20, 32'h0BAD_F00D);
         wb_xfer(32'h0000_0000, 1'b0, 32'h0, 40, ok, rd, lat);
      join
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'h0BAD_F00D})
         $display("FAIL no_timeout_dat: got ack=%b %h, expected ack=1 0badf00d", ok, rd);
      else n_pass++;
      n_chk++;
      if (irq_o !== 1'b0) $display("FAIL no_timeout_irq: got %b, expected 0", irq_o);
      else n_pass++;
   endtask

   task automatic test_cyc_drop();
      logic ok;
      logic [31:0] rd;
      int lat;
      logic ack_seen = 1'b0;
      @(negedge wb_clk_i);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = 32'h0000_0000;
      repeat (2) @(negedge wb_clk_i);
      n_chk++;
      if (s0_stb_o !== 1'b1) $display("FAIL drop_fwd_stb: got %b, expected 1", s0_stb_o);
      else n_pass++;
      drive_idle();
      @(negedge wb_clk_i);
      n_chk++;
      if ({s0_cyc_o, s0_stb_o} !== 2'b00)
         $display("FAIL drop_stb_low: got %b, expected 00", {s0_cyc_o, s0_stb_o});
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge wb_clk_i);
         if (bus.wbs_ack_o) ack_seen = 1'b1;
      end
      n_chk++;
      if (ack_seen !== 1'b0) $display("FAIL drop_no_ack: got %b, expected 0", ack_seen);
      else n_pass++;
      wb_xfer(32'h0000_200C, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'h2})
         $display("FAIL drop_cnt0: got ack=%b %h, expected ack=1 00000002", ok, rd);
      else n_pass++;
      wb_xfer(32'h0000_200C, 1'b1, 32'h0, 10, ok, rd, lat);
      wb_xfer(32'h0000_200C, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h0) $display("FAIL cnt0_clear: got %h, expected 0", rd);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic ok;
      logic [31:0] rd;
      int lat;
      logic ack_seen = 1'b0;
      wb_xfer(32'h0000_2000, 1'b1, 32'h0000_0001, 10, ok, rd, lat);
      @(negedge wb_clk_i);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = 32'h0000_0000;
      repeat (2) @(negedge wb_clk_i);
      wb_rst_ni = 1'b0;
      @(negedge wb_clk_i);
      n_chk++;
      if ({s0_stb_o, bus.wbs_ack_o} !== 2'b00)
         $display("FAIL midrst_outputs: got stb/ack=%b, expected 00", {s0_stb_o, bus.wbs_ack_o});
      else n_pass++;
      drive_idle();
      wb_rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge wb_clk_i);
         if (bus.wbs_ack_o) ack_seen = 1'b1;
      end
      n_chk++;
      if (ack_seen !== 1'b0) $display("FAIL midrst_no_ack: got %b, expected 0", ack_seen);
      else n_pass++;
      wb_xfer(32'h0000_2000, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'h3) $display("FAIL midrst_ctrl: got %h, expected 3", rd);
      else n_pass++;
      wb_xfer(32'h0000_2004, 1'b0, 32'h0, 10, ok, rd, lat);
      n_chk++;
      if (rd !== 32'hFF) $display("FAIL midrst_timeout: got %h, expected ff", rd);
      else n_pass++;
      fork
         slave_respond(0, 1, 32'h5A5A_A5A5);
         wb_xfer(32'h0000_0000, 1'b0, 32'h0, 20, ok, rd, lat);
      join
      n_chk++;
      if ({ok, rd} !== {1'b1, 32'h5A5A_A5A5})
         $display("FAIL midrst_next_read: got ack=%b %h, expected ack=1 5a5aa5a5", ok, rd);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_slave_read();
      test_unmapped();
      test_disabled_slave();
      test_timeout();
      test_ack_vs_timeout();
      test_timeout_disabled();
      test_cyc_drop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
